// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller: register map, ACK word layout, FSM encoding.
package pic_pkg;

  localparam logic [1:0] PIC_PEND = 2'd0;
  localparam logic [1:0] PIC_MASK = 2'd1;
  localparam logic [1:0] PIC_ACK  = 2'd2;
  localparam logic [1:0] PIC_EOI  = 2'd3;

  localparam int ACK_VLD_BIT = 15;
  localparam int ACK_ID_LSB  = 0;
  localparam int ACK_ID_W    = 3;

  localparam logic [15:0] MASK_RST = 16'h00FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } pic_state_t;

  function automatic logic [15:0] ack_word(input logic vld, input logic [2:0] id);
    logic [15:0] w;
    w = '0;
    w[ACK_VLD_BIT] = vld;
    w[ACK_ID_LSB +: ACK_ID_W] = id;
    return w;
  endfunction

endpackage

// File: rtl/pic_sync.sv
// Two-flop synchronizer per IRQ line plus rising-edge detect.
// Edge pulse is high for one clock, two clocks after the line is first sampled high.
module pic_sync #(
  parameter int N = 8
) (
  input  logic         _CLK,
  input  logic         _RST,
  input  logic [N-1:0] irq,
  output logic [N-1:0] irq_edge
);

  logic [N-1:0] s1, s2, s3;

  always_ff @(posedge _CLK) begin
    if (_RST) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign irq_edge = s2 & ~s3;

endmodule

// File: rtl/pic.sv
// Bus-mapped interrupt controller: edge-latched pending bits, mask, fixed priority (line 0 highest),
// one line in service from ACK read to EOI write; PIC_I is registered.
module pic
  import pic_pkg::*;
#(
  parameter logic [22:0] BASE  = 23'h7FFFF0,
  parameter int          N_IRQ = 8
) (
  input  logic             _CLK,
  input  logic             _RST,
  input  logic [N_IRQ-1:0] IRQ,
  input  logic [22:0]      BUS_A,
  inout  wire  [15:0]      BUS_D,
  input  logic             BUS_R,
  input  logic             BUS_W,
  output logic             PIC_I
);

  logic [N_IRQ-1:0] pend, mask, irq_edge, elig, ack_clr, w1c_clr;
  logic [2:0]       svc_id, pri_id;
  logic [22:0]      off;
  logic [1:0]       reg_sel;
  logic [15:0]      rd_dat, ack_dat;
  logic             hit, rd_acc, wr_acc, rd_q, wr_q, rd_fire, wr_fire;
  logic             any_elig, ack_take, eoi_take, mask_wr;
  logic             unused_bus;
  pic_state_t       st, st_nxt;

  pic_sync #(.N(N_IRQ)) u_sync (
    ._CLK     (_CLK),
    ._RST     (_RST),
    .irq      (IRQ),
    .irq_edge (irq_edge)
  );

  assign off     = BUS_A - BASE;
  assign hit     = (off[22:2] == '0);
  assign reg_sel = off[1:0];
  assign rd_acc  = BUS_R & ~BUS_W & hit;
  assign wr_acc  = BUS_W & ~BUS_R & hit;
  // Effects fire only on the first clock of an access, so a held strobe acts once.
  assign rd_fire = rd_acc & ~rd_q;
  assign wr_fire = wr_acc & ~wr_q;

  assign elig     = pend & ~mask;
  assign any_elig = |elig;
  assign ack_take = rd_fire && (reg_sel == PIC_ACK) && (st != SVC) && any_elig;
  assign eoi_take = wr_fire && (reg_sel == PIC_EOI) && (st == SVC);
  assign mask_wr  = wr_fire && (reg_sel == PIC_MASK);

  always_comb begin
    pri_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) pri_id = 3'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    w1c_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      ack_clr[i] = ack_take && (pri_id == 3'(i));
      w1c_clr[i] = wr_fire && (reg_sel == PIC_PEND) && BUS_D[i];
    end
  end

  always_comb begin
    if (st == SVC)     ack_dat = ack_word(1'b1, svc_id);
    else if (any_elig) ack_dat = ack_word(1'b1, pri_id);
    else               ack_dat = '0;
  end

  always_comb begin
    rd_dat = '0;
    case (reg_sel)
      PIC_PEND: rd_dat = 16'(pend);
      PIC_MASK: rd_dat = 16'(mask);
      PIC_ACK:  rd_dat = ack_dat;
      default:  rd_dat = '0;
    endcase
  end

  assign BUS_D      = rd_acc ? rd_dat : 'z;
  assign unused_bus = ^BUS_D;

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (ack_take)      st_nxt = SVC;
        else if (any_elig) st_nxt = REQ;
      end
      REQ: begin
        if (ack_take)       st_nxt = SVC;
        else if (!any_elig) st_nxt = IDLE;
      end
      SVC: begin
        if (eoi_take) st_nxt = any_elig ? REQ : IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge _CLK) begin
    if (_RST) begin
      pend   <= '0;
      mask   <= MASK_RST[N_IRQ-1:0];
      st     <= IDLE;
      svc_id <= '0;
      PIC_I  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      // New edges are OR-ed in last so a set beats a same-cycle clear.
      pend <= (pend & ~w1c_clr & ~ack_clr) | irq_edge;
      if (mask_wr) mask <= BUS_D[N_IRQ-1:0];
      st <= st_nxt;
      if (ack_take)      svc_id <= pri_id;
      else if (eoi_take) svc_id <= '0;
      PIC_I <= (st_nxt == REQ);
      rd_q  <= BUS_R;
      wr_q  <= BUS_W;
    end
  end

endmodule

// File: tb/tb_pic.sv
// Scoreboard bench for pic: stimulus queues expected values, a negedge monitor pops and compares.
module tb_pic;

  localparam logic [22:0] B = 23'h7FFFF0;

  logic        clk = 1'b0;
  logic        rst, bus_r, bus_w, tb_drv, pic_i, probe;
  logic [7:0]  irq;
  logic [22:0] bus_a;
  logic [15:0] tb_dat;
  wire  [15:0] bus_d;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        is_pic;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];

  assign bus_d = tb_drv ? tb_dat : 'z;

  always #5 clk = ~clk;

  pic dut (
    ._CLK  (clk),
    ._RST  (rst),
    .IRQ   (irq),
    .BUS_A (bus_a),
    .BUS_D (bus_d),
    .BUS_R (bus_r),
    .BUS_W (bus_w),
    .PIC_I (pic_i)
  );

  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: probe with no expected entry");
      end else begin
        exp_t e;
        logic [15:0] act;
        e = exp_q.pop_front();
        act = e.is_pic ? {15'b0, pic_i} : bus_d;
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string n, input logic is_pic, input logic [15:0] v);
    exp_t e;
    e.name = n;
    e.is_pic = is_pic;
    e.val = v;
    exp_q.push_back(e);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic check_pic(input string n, input logic v);
    expect_val(n, 1'b1, {15'b0, v});
  endtask

  task automatic bus_read(input logic [1:0] off, input logic [15:0] v, input string n, input int hold);
    bus_a = B + {21'b0, off};
    bus_r = 1'b1;
    for (int h = 0; h < hold; h++) expect_val(n, 1'b0, v);
    bus_r = 1'b0;
    tick();
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [15:0] d);
    bus_a  = B + {21'b0, off};
    tb_dat = d;
    tb_drv = 1'b1;
    bus_w  = 1'b1;
    tick();
    bus_w  = 1'b0;
    tb_drv = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic [7:0] v);
    irq = v;
    repeat (3) tick();
    irq = '0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq = '0; bus_r = 1'b0; bus_w = 1'b0; tb_drv = 1'b0;
    tb_dat = '0; bus_a = '0; probe = 1'b0;
    tick(); tick();
    check_pic("reset_pic", 1'b0);
    rst = 1'b0;
    bus_read(2'd1, 16'h00FF, "reset_mask", 1);
    bus_read(2'd0, 16'h0000, "reset_pend", 1);

    // Lines 1 and 2 together, line 1 wins
    bus_write(2'd1, 16'h00F0);
    irq = 8'h06;
    tick(); tick(); tick();
    irq = '0;
    check_pic("irq_pic_before_k3", 1'b0);
    check_pic("irq_pic_at_k3", 1'b1);
    bus_read(2'd0, 16'h0006, "pend_1_2", 1);
    bus_read(2'd2, 16'h8001, "ack_line1", 1);
    bus_read(2'd0, 16'h0004, "pend_after_ack1", 1);
    check_pic("svc_pic_low", 1'b0);

    bus_write(2'd3, 16'h0000);
    check_pic("eoi_rereq", 1'b1);
    bus_read(2'd2, 16'h8002, "ack_line2", 1);
    check_pic("svc2_pic_low", 1'b0);
    bus_write(2'd3, 16'h0000);
    check_pic("eoi_to_idle", 1'b0);
    bus_read(2'd2, 16'h0000, "ack_empty", 1);
    bus_read(2'd0, 16'h0000, "pend_empty", 1);

    // Masked pending line, then unmask and W1C
    bus_write(2'd1, 16'h00FF);
    pulse(8'h20);
    check_pic("masked_pic", 1'b0);
    bus_read(2'd0, 16'h0020, "pend_masked5", 1);
    bus_write(2'd1, 16'h0000);
    check_pic("unmask_pic", 1'b1);
    bus_write(2'd0, 16'h0020);
    check_pic("w1c_pic", 1'b0);
    bus_read(2'd0, 16'h0000, "pend_after_w1c", 1);

    // Held ACK strobe acknowledges once
    pulse(8'h18);
    check_pic("req_3_4", 1'b1);
    bus_read(2'd2, 16'h8003, "ack_held", 4);
    bus_read(2'd0, 16'h0010, "pend_after_held", 1);
    check_pic("held_svc_pic", 1'b0);
    bus_read(2'd2, 16'h8003, "ack_in_svc", 1);
    bus_read(2'd0, 16'h0010, "pend_unchanged_svc", 1);

    // Re-edge on the in-service line is serviced after EOI
    pulse(8'h08);
    check_pic("reedge_svc_pic", 1'b0);
    bus_write(2'd3, 16'h0000);
    check_pic("reedge_eoi_pic", 1'b1);
    bus_read(2'd2, 16'h8003, "ack_reedge", 1);

    // Edge coinciding with W1C of the same bit
    pulse(8'h40);
    irq = 8'h40;
    tick(); tick();
    bus_write(2'd0, 16'h0040);
    irq = '0;
    tick(); tick();
    bus_read(2'd0, 16'h0050, "set_beats_w1c", 1);
    bus_write(2'd0, 16'h0040);
    bus_read(2'd0, 16'h0010, "w1c_bit6", 1);

    // Both strobes: no drive, no write
    bus_a = B; bus_r = 1'b1; bus_w = 1'b1; tb_dat = 16'hA5A5; tb_drv = 1'b1;
    expect_val("both_no_drive", 1'b0, 16'hA5A5);
    bus_r = 1'b0; bus_w = 1'b0; tb_drv = 1'b0;
    tick();
    bus_a = B + 23'd1; bus_r = 1'b1; bus_w = 1'b1; tb_dat = 16'h00FF; tb_drv = 1'b1;
    tick();
    bus_r = 1'b0; bus_w = 1'b0; tb_drv = 1'b0;
    tick();
    bus_read(2'd1, 16'h0000, "both_no_write", 1);
    bus_write(2'd1, 16'hFF00);
    bus_read(2'd1, 16'h0000, "mask_upper_bits", 1);

    // Reset while in service with lines 0 and 4 pending
    pulse(8'h01);
    bus_read(2'd0, 16'h0011, "pend_pre_reset", 1);
    check_pic("svc_pre_reset", 1'b0);
    bus_write(2'd1, 16'h0003);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_pic("post_reset_pic", 1'b0);
    bus_read(2'd1, 16'h00FF, "post_reset_mask", 1);
    bus_read(2'd0, 16'h0000, "post_reset_pend", 1);
    bus_read(2'd2, 16'h0000, "post_reset_ack", 1);
    bus_write(2'd1, 16'h0000);
    check_pic("post_reset_idle", 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pic.md
# pic

Programmable interrupt controller (`pic`) that drives the `PIC_I` request consumed by execute_control. It sits on the system bus (`BUS_A`/`BUS_D`/`BUS_R`/`BUS_W`) alongside the devices. It latches rising edges on eight external interrupt lines, applies a software mask and fixed priority, and holds one interrupt in service from acknowledge until end-of-interrupt (EOI).

## Interface
- `BASE`, default 23'h7FFFF0: bus address of register 0; registers occupy `BASE`..`BASE+3`.
- `N_IRQ`, default 8: number of interrupt lines (1..8).
- `_CLK`  in  1  system clock; all logic on its rising edge.
- `_RST`  in  1  reset, synchronous, active-high.
- `IRQ`  in  N_IRQ  asynchronous interrupt lines; a rising edge requests service.
- `BUS_A`  in  23  bus address.
- `BUS_D`  inout  16  bus data; driven only during a decoded read, otherwise high-Z.
- `BUS_R`  in  1  bus read strobe, held for the whole access.
- `BUS_W`  in  1  bus write strobe, held for the whole access.
- `PIC_I`  out  1  registered interrupt request to execute_control.

## Operation
- Registers (offset: function):
  - 0 PEND: read returns pending bits in [N_IRQ-1:0]. Writing 1 to a bit clears it (W1C).
  - 1 MASK: read/write. A 1 masks the line. Reset value 16'h00FF.
  - 2 ACK: a read returns {valid, 12'b0, id[2:0]} in [15], [14:3], [2:0] respectively.
    - If `valid`=1, the read moves the highest-priority unmasked pending line into service and clears its PEND bit.
    - If nothing is eligible, the read returns 16'h0000 and changes no state.
  - 3 EOI: any write clears in-service.
- Priority: line 0 is highest.
- State machine (`st`):
  - IDLE: no eligible pending line.
  - REQ: eligible pending line exists and nothing is in service; `PIC_I`=1.
  - SVC: a line is in service; `PIC_I`=0.
- Transitions:
  - IDLE→REQ when eligible.
  - REQ→SVC on an ACK read with valid=1.
  - REQ→IDLE if eligibility disappears, through a mask or W1C write.
  - SVC→REQ on EOI if eligible; SVC→IDLE on EOI otherwise.
- Side effects of reads and writes occur exactly once per access. They fire on the first clock at which the strobe is high and `BUS_A` decodes (edge of registered strobe). Holding a strobe does not repeat the effect.
- Read data is combinational from current state while `BUS_R` is high and the address decodes.
- Boundary conditions:
  - A new edge and a W1C of the same bit in the same cycle: set wins.
  - A new edge on the in-service line while in SVC: sets PEND and is serviced after EOI.
  - ACK read while in SVC: returns the current in-service id with valid=1 and changes no state.
  - EOI while IDLE or REQ: ignored.
  - `BUS_R` and `BUS_W` both high: the access is ignored and `BUS_D` is not driven.
  - Bits above N_IRQ-1 read 0 and ignore writes.
  - Reset mid-access or mid-service:
    - PEND=0, in-service cleared, `st`=IDLE.
    - MASK=16'h00FF.
    - Synchronizers cleared.
    - `PIC_I`=0 on the first clock after reset is sampled.

## Timing
- Reset values: `PIC_I`=0, `BUS_D`=Z, PEND=0, MASK=16'h00FF, `st`=IDLE.
- IRQ path: two-flop synchronizer, then an edge register.
  - IRQ first sampled high at clock k sets PEND at clock k+2.
  - `PIC_I` rises at clock k+3.
  - An IRQ pulse must be high for at least 2 clocks to be guaranteed captured.
- ACK read decoded at clock j: `st`=SVC and `PIC_I`=0 at j+1.
- EOI at clock j with another eligible line: `PIC_I`=1 at j+1.
- A MASK write at clock j takes effect for eligibility at j+1; `PIC_I` follows at j+2.

## Structure
- `pic_pkg` holds:
  - register offsets `PIC_PEND`/`PIC_MASK`/`PIC_ACK`/`PIC_EOI`;
  - ACK field positions;
  - the `pic_state_t` encoding (IDLE/REQ/SVC);
  - the MASK reset constant.
- `pic_sync` sub-module: per-line two-flop synchronizer plus rising-edge detect. It takes `_CLK`/`_RST` and outputs a one-clock `edge` pulse.
- Top level holds the PEND/MASK/in-service registers, priority encoder, FSM, bus decode and tristate driver.

## Test plan
- Reset, then read MASK → 16'h00FF. Read PEND → 0. `PIC_I`=0.
- Write MASK=16'h00F0, pulse IRQ[2] and IRQ[1] together → PEND=16'h0006 and `PIC_I`=1 three clocks after IRQ. ACK read → 16'h8001 and PEND=16'h0004.
- In SVC, write EOI → `PIC_I`=1 the next clock. ACK → 16'h8002. EOI → `st`=IDLE and `PIC_I`=0.
- Pend IRQ[5] while MASK=16'h00FF → `PIC_I`=0 and PEND=16'h0020. Write MASK=0 → `PIC_I`=1 two clocks later. W1C write 16'h0020 → `PIC_I`=0.
- ACK read with nothing pending → 16'h0000 and no state change. Hold `BUS_R` for 4 clocks on ACK while line 3 is pending → exactly one acknowledge, returning 16'h8003.
- Assert `_RST` for 1 clock while in SVC with PEND=16'h0011 → all reset values restored the next clock.
